// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin arbiter for the shared 16-bit tri-state system
//               bus. Grants one master at a time and inserts a one-cycle
//               turnaround between owners. It revokes any grant held for
//               MAX_HOLD cycles and locks that master out until it drops req.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 64,
  parameter int HOLD_W   = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            busy,
  output logic            timeout_err
);

  // One extra bit so that ptr + offset can exceed NREQ-1 before wrapping
  localparam int c_SUM_W = IDW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  state_t            r_state;
  logic [IDW-1:0]    r_ptr;
  logic [NREQ-1:0]   r_lock;
  logic [HOLD_W-1:0] r_cnt;
  logic [NREQ-1:0]   r_grant;
  logic [IDW-1:0]    r_grant_id;
  logic              r_busy;
  logic              r_timeout_err;

  logic [NREQ-1:0]   w_eff;
  logic              w_found;
  logic [IDW-1:0]    w_pick;
  logic [NREQ-1:0]   w_pick_oh;
  logic [c_SUM_W-1:0] w_sum;
  logic [IDW-1:0]    w_idx;
  logic [IDW-1:0]    w_next_ptr;
  logic              w_owner_req;
  logic              w_hold_max;

  // Locked-out masters are invisible to arbitration until they drop req
  assign w_eff = req & ~r_lock;

  // Round-robin pick: first eligible requester scanning from ptr upward, wrapping
  always_comb begin
    w_found   = 1'b0;
    w_pick    = '0;
    w_pick_oh = '0;
    w_sum     = '0;
    w_idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, r_ptr} + c_SUM_W'(i);
      if (w_sum >= c_SUM_W'(NREQ)) begin
        w_sum = w_sum - c_SUM_W'(NREQ);
      end
      w_idx = w_sum[IDW-1:0];
      if (!w_found && w_eff[w_idx]) begin
        w_found          = 1'b1;
        w_pick           = w_idx;
        w_pick_oh[w_idx] = 1'b1;
      end
    end
  end

  // Fairness pointer moves to the master after the one releasing the bus
  assign w_next_ptr  = (r_grant_id == IDW'(NREQ - 1)) ? '0 : r_grant_id + 1'b1;
  assign w_owner_req = req[r_grant_id];
  assign w_hold_max  = (r_cnt == HOLD_W'(MAX_HOLD - 1));

  // Arbitration FSM; all outputs are registered so grant never glitches
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_lock        <= '0;
      r_cnt         <= '0;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      r_lock        <= r_lock & req;
      case (r_state)
        S_IDLE, S_TURN: begin
          if (w_found) begin
            r_grant    <= w_pick_oh;
            r_grant_id <= w_pick;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_GRANT;
          end else begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_GRANT: begin
          // A dropped request wins over the hold limit: that is a normal release
          if (!w_owner_req || w_hold_max) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_next_ptr;
            r_state <= S_TURN;
            if (w_owner_req) begin
              r_timeout_err <= 1'b1;
              r_lock        <= (r_lock & req) | r_grant;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Directed self-checking bench for bus_arbiter (MAX_HOLD=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .NREQ    (4),
    .IDW     (2),
    .MAX_HOLD(8),
    .HOLD_W  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge, check invariants
  task automatic step();
    @(posedge clk);
    #1;
    chk("onehot0", {7'd0, $onehot0(grant)}, 8'd1);
    chk("busy_eq_or_grant", {7'd0, busy}, {7'd0, |grant});
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic b,
                         input logic [1:0] id, input logic to);
    chk({tag, "_grant"},   {4'd0, grant},       {4'd0, g});
    chk({tag, "_busy"},    {7'd0, busy},        {7'd0, b});
    chk({tag, "_id"},      {6'd0, grant_id},    {6'd0, id});
    chk({tag, "_timeout"}, {7'd0, timeout_err}, {7'd0, to});
  endtask

  initial begin
    logic [3:0] oh;
    logic [3:0] prev_oh;
    int k;

    // Reset state
    rst = 1'b1;
    req = 4'b0000;
    step();
    step();
    chk_all("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;

    // 1: basic grant, release, turnaround, next owner
    req = 4'b0101;
    step(); chk_all("t1_g0", 4'b0001, 1'b1, 2'd0, 1'b0);
    req = 4'b0100;
    step(); chk_all("t1_turn", 4'b0000, 1'b0, 2'd0, 1'b0);
    step(); chk_all("t1_g2", 4'b0100, 1'b1, 2'd2, 1'b0);
    req = 4'b0000;
    step(); chk_all("t1_rel", 4'b0000, 1'b0, 2'd2, 1'b0);
    step(); chk_all("t1_idle", 4'b0000, 1'b0, 2'd2, 1'b0);

    // Bring ptr back to 0 for the fairness sequence
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all("rst2", 4'b0000, 1'b0, 2'd0, 1'b0);

    // 2: fairness, grant order 0,1,2,3,0,1 with one idle cycle between owners
    for (int n = 0; n < 6; n++) begin
      k       = n % 4;
      oh      = 4'b0001 << k;
      prev_oh = 4'b0001 << ((n + 3) % 4);
      req = (n == 0) ? 4'b1111 : (4'b1111 & ~prev_oh);
      step(); chk_all("t2_grant", oh, 1'b1, 2'(k), 1'b0);
      req = 4'b1111;
      step(); chk_all("t2_hold1", oh, 1'b1, 2'(k), 1'b0);
      step(); chk_all("t2_hold2", oh, 1'b1, 2'(k), 1'b0);
      req = 4'b1111 & ~oh;
      step(); chk_all("t2_turn", 4'b0000, 1'b0, 2'(k), 1'b0);
    end
    req = 4'b0000;
    step(); chk_all("t2_idle", 4'b0000, 1'b0, 2'd1, 1'b0);

    // 3: timeout of a stuck master, lockout until it drops req
    req = 4'b1100;
    step(); chk_all("t3_g2", 4'b0100, 1'b1, 2'd2, 1'b0);
    for (int i = 1; i < 8; i++) begin
      step(); chk_all("t3_hold", 4'b0100, 1'b1, 2'd2, 1'b0);
    end
    step(); chk_all("t3_timeout", 4'b0000, 1'b0, 2'd2, 1'b1);
    step(); chk_all("t3_g3", 4'b1000, 1'b1, 2'd3, 1'b0);
    req = 4'b0100;
    step(); chk_all("t3_rel3", 4'b0000, 1'b0, 2'd3, 1'b0);
    step(); chk_all("t3_locked_a", 4'b0000, 1'b0, 2'd3, 1'b0);
    step(); chk_all("t3_locked_b", 4'b0000, 1'b0, 2'd3, 1'b0);
    req = 4'b0000;
    step(); chk_all("t3_unlock", 4'b0000, 1'b0, 2'd3, 1'b0);
    req = 4'b0100;
    step(); chk_all("t3_regrant", 4'b0100, 1'b1, 2'd2, 1'b0);
    req = 4'b0000;
    step(); chk_all("t3_rel2", 4'b0000, 1'b0, 2'd2, 1'b0);
    step();

    // 4: request drops on the last allowed cycle -> normal release, no lock
    req = 4'b0010;
    step(); chk_all("t4_g1", 4'b0010, 1'b1, 2'd1, 1'b0);
    for (int i = 1; i < 8; i++) begin
      step(); chk_all("t4_hold", 4'b0010, 1'b1, 2'd1, 1'b0);
    end
    req = 4'b0000;
    step(); chk_all("t4_rel", 4'b0000, 1'b0, 2'd1, 1'b0);
    req = 4'b0010;
    step(); chk_all("t4_nolock", 4'b0010, 1'b1, 2'd1, 1'b0);
    req = 4'b0000;
    step();
    step();

    // 5: reset in the middle of a grant, ptr restarts at 0
    req = 4'b1000;
    step(); chk_all("t5_g3", 4'b1000, 1'b1, 2'd3, 1'b0);
    step(); chk_all("t5_hold", 4'b1000, 1'b1, 2'd3, 1'b0);
    rst = 1'b1;
    step(); chk_all("t5_rst", 4'b0000, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    req = 4'b1010;
    step(); chk_all("t5_ptr0", 4'b0010, 1'b1, 2'd1, 1'b0);
    req = 4'b0000;
    step();
    step();

    // 6: single master re-granted right after the turnaround cycle
    req = 4'b0010;
    step(); chk_all("t6_g1", 4'b0010, 1'b1, 2'd1, 1'b0);
    step(); chk_all("t6_hold", 4'b0010, 1'b1, 2'd1, 1'b0);
    req = 4'b0000;
    step(); chk_all("t6_turn", 4'b0000, 1'b0, 2'd1, 1'b0);
    req = 4'b0010;
    step(); chk_all("t6_regrant", 4'b0010, 1'b1, 2'd1, 1'b0);
    req = 4'b0000;
    step();
    step(); chk_all("t6_idle", 4'b0000, 1'b0, 2'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
